mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Requester-side controller for Data_memory (clk/enable/addr/dataIn/dataOut).
//  Accepts byte/half/word load-store requests from the core over valid/ready,
//  drives the memory enable/addr/dataIn pins, captures dataOut, and returns
//  aligned, sign/zero-extended load data. Sub-word stores use read-modify-write.
// PARAMETERS
//  ADDR_W   32  byte-address width of req_addr; mem_addr = req_addr >> 2
//  DATA_W   32  memory word width (fixed 32; byte lanes assume 4 bytes)
// PORTS
//  clk         in   1       single clock, all state on posedge
//  rst_n       in   1       synchronous active-low reset
//  req_valid   in   1       request present
//  req_ready   out  1       controller can accept (IDLE only)
//  req_we      in   1       1 = store, 0 = load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 reserved
//  req_signed  in   1       load sign-extend (ignored for stores/word)
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data, right-justified
//  resp_valid  out  1       response present; held until resp_ready
//  resp_ready  in   1       core accepts response
//  resp_rdata  out  32      load result (0 for stores)
//  resp_err    out  1       misaligned access flag (macro only; else 0)
//  mem_enable  out  1       write enable to Data_memory (dataIn written at posedge)
//  mem_addr    out  32      word index to Data_memory
//  mem_din     out  32      write data to Data_memory
//  mem_dout    in   32      read data from Data_memory
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state=IDLE; req_ready=1, resp_valid=0,
//    resp_rdata=0, resp_err=0, mem_enable=0, mem_addr=0, mem_din=0. Reset
//    mid-transaction aborts it; no write issued after the reset edge.
//  - FSM: IDLE, RD, CAP, WR, RESP. Handshake fires when req_valid&&req_ready;
//    request fields latched on that edge, inputs ignored until back in IDLE.
//  - IDLE -> RD for loads and sub-word stores; IDLE -> WR for word stores.
//  - RD: mem_addr=word index, mem_enable=0; -> CAP next cycle.
//  - CAP: mem_dout sampled into buffer. Load -> RESP; sub-word store -> WR.
//  - WR: mem_enable=1 for exactly one cycle; mem_din = buffer with lane(s)
//    selected by addr[1:0] replaced (byte lane addr[1:0], half lane addr[1]);
//    word store writes req_wdata directly. -> RESP.
//  - RESP: resp_valid=1; on resp_ready -> IDLE (req_ready=1 next cycle).
//    No back-to-back overlap; one transaction outstanding.
//  - Latency from accept edge to resp_valid: load 3, word store 2, sub-word 4.
//  - Load extract: byte = word[8*addr[1:0]+:8], half = word[16*addr[1]+:16];
//    req_signed=1 sign-extends, else zero-extends. Little-endian lanes.
//  - mem_enable=0 in every state except WR. mem_addr held through WR.
//  - size 11 treated as word. Word address wraps modulo 2^(ADDR_W-2).
// CONFIGURATION
//  MEM_CTRL_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with
//    addr[1:0]!=0 -> IDLE goes straight to RESP, no memory access,
//    resp_err=1, resp_rdata=0. size 11 also traps.
//  Undefined: misaligned low bits forced to lane alignment (half uses
//    addr[1], word ignores addr[1:0]); resp_err tied 0.
// TESTING
//  1 Reset: rst_n=0 two cycles -> all outputs at reset values, req_ready=1.
//  2 Word store 0xFFFFFFFF @ byte 0x28 -> one cycle mem_enable=1, mem_addr=0xA,
//    resp_valid 2 cycles after accept; word load @0x28 -> 0xFFFFFFFF at +3.
//  3 Preload word 0x11223344 @0x04; byte store 0xAB @0x06 -> memory 0x11AB3344;
//    signed byte load @0x06 -> 0xFFFFFFAB, unsigned -> 0x000000AB.
//  4 Half load @0x06 from 0x81223344, signed -> 0xFFFF8122; unsigned 0x00008122.
//  5 Hold resp_ready=0 five cycles -> resp_valid/rdata stable, req_ready=0,
//    no mem_enable; reset asserted during WR-bound store -> no write occurs.
//  6 Misaligned word load @0x05: macro on -> resp_err=1 at +1, no mem access;
//    macro off -> reads word index 1, resp_err=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Requester-side controller for a simple Data_memory (enable/addr/dataIn/
// dataOut, asynchronous read, write on posedge while enable is high).
// It accepts one byte/half/word load or store from the core, runs it against
// the memory and returns aligned, sign/zero-extended load data.
// Sub-word stores use read-modify-write.
//
// Optional feature macro: MEM_CTRL_MISALIGN_TRAP_EN
//   defined   : misaligned half/word accesses and size 2'b11 are not sent to
//               memory; they answer right away with resp_err=1 and rdata=0.
//   undefined : misaligned low address bits are forced to lane alignment and
//               resp_err is always 0.
//
// Handshakes (both ports): a transfer happens on a rising edge where
// valid && ready are both high. req_ready is high only in IDLE, so at most
// one transaction is in flight. resp_valid stays high, with resp_rdata and
// resp_err stable, until resp_ready is seen.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 reserved (word)
//   req_signed            sign-extend sub-word loads
//   req_addr              byte address
//   req_wdata             store data, right-justified
//   resp_valid/resp_ready response handshake
//   resp_rdata            load result (0 for stores and traps)
//   resp_err              misaligned access flag
//   mem_enable            memory write enable (high only in WR)
//   mem_addr              word index (req_addr >> 2)
//   mem_din               memory write data
//   mem_dout              memory read data
//   dbg_state             current FSM state, for observation only
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_enable,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [1:0]  req_eff_size;
  logic [1:0]  req_off;
  logic [31:0] req_word_idx;
  logic        req_trap;

  // Reserved size behaves as a word access.
  assign req_eff_size = (req_size == 2'b11) ? SZ_WORD : req_size;
  assign req_word_idx = 32'(req_addr[ADDR_W-1:2]);

  // Byte offset of the selected lane; low bits a half or word cannot use are
  // dropped so misaligned requests land on their natural lane.
  always_comb begin
    req_off = 2'b00;
    case (req_eff_size)
      SZ_BYTE: req_off = req_addr[1:0];
      SZ_HALF: req_off = {req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  assign req_trap = (req_size == 2'b11) ||
                    ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign req_trap = 1'b0;
`endif

  // Pull the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [31:0] sh;
    logic [31:0] res;
    sh = w >> {off, 3'b000};
    case (sz)
      SZ_BYTE: res = sgn ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
      SZ_HALF: res = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  // Replace the addressed lane(s) of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                              input logic [31:0] wd,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off);
    logic [31:0] lane_mask;
    logic [31:0] res;
    lane_mask = (sz == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
    if (sz == SZ_WORD) begin
      res = wd;
    end else begin
      res = (old_w & ~(lane_mask << {off, 3'b000})) |
            ((wd & lane_mask) << {off, 3'b000});
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    signed_d   = signed_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_eff_size;
          signed_d   = req_signed;
          off_d      = req_off;
          wdata_d    = req_wdata;
          mem_addr_d = req_word_idx;
          rdata_d    = 32'h0;
          err_d      = 1'b0;
          if (req_trap) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (req_we && (req_eff_size == SZ_WORD)) begin
            // Full-word store needs no read of the old contents.
            mem_din_d = req_wdata;
            state_d   = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        state_d = ST_CAP;
      end
      ST_CAP: begin
        if (we_q) begin
          mem_din_d = store_merge(mem_dout, wdata_q, size_q, off_q);
          state_d   = ST_WR;
        end else begin
          rdata_d = load_extract(mem_dout, size_q, off_q, signed_q);
          state_d = ST_RESP;
        end
      end
      ST_WR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      off_q      <= 2'b00;
      wdata_q    <= 32'h0;
      mem_addr_q <= 32'h0;
      mem_din_q  <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign mem_enable = (state_q == ST_WR);
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Drives mem_access_ctrl against a behavioural Data_memory and checks every
// response against a byte-addressed reference memory kept in the bench.
// Directed steps cover reset, word/byte/half accesses, response back-pressure,
// reset during a store and a misaligned word load; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [2:0]  dbg_state;

  mem_access_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_enable (mem_enable),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .dbg_state  (dbg_state)
  );

  // ---------------- Data_memory model (64 words, aliased by index) ----------
  logic [31:0] phys [64];
  logic        clr_mem = 1'b1;
  int          wr_cnt;
  logic [31:0] last_wr_data;

  assign mem_dout = phys[mem_addr[5:0]];

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) phys[i] <= 32'h0;
      wr_cnt       <= 0;
      last_wr_data <= 32'h0;
    end else if (mem_enable) begin
      phys[mem_addr[5:0]] <= mem_din;
      wr_cnt              <= wr_cnt + 1;
      last_wr_data        <= mem_din;
    end
  end

  // ---------------- reference model: byte memory ----------------
  logic [7:0]  ref_bytes [256];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] ref_word(input int w);
    return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
  endfunction

  // Transaction-level expectation: returns rdata, err, cycles from the
  // accept edge to resp_valid, and number of memory writes; applies stores.
  function automatic void model(input logic we, input logic [1:0] sz,
                                input logic sg, input logic [31:0] addr,
                                input logic [31:0] wd,
                                output logic [31:0] rd, output logic err,
                                output int lat, output int nwr);
    int    nbytes;
    int    a8;
    int    base;
    longint val;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    if ((sz == 2'b11) || ((int'(addr[1:0]) % nbytes) != 0)) begin
      rd = 32'h0; err = 1'b1; lat = 1; nwr = 0;
      return;
    end
`endif
    a8   = int'(addr[7:0]);
    base = a8 - (a8 % nbytes);
    err  = 1'b0;
    if (we) begin
      for (int i = 0; i < nbytes; i++) ref_bytes[base+i] = wd[8*i +: 8];
      rd  = 32'h0;
      nwr = 1;
      lat = (nbytes == 4) ? 2 : 4;
    end else begin
      val = 0;
      for (int i = 0; i < nbytes; i++) val = val | (longint'(ref_bytes[base+i]) << (8*i));
      if (sg && nbytes < 4 && val >= (64'sd1 <<< (8*nbytes-1)))
        val = val - (64'sd1 <<< (8*nbytes));
      rd  = val[31:0];
      nwr = 0;
      lat = 3;
    end
  endfunction

  // ---------------- comparison ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] obs_rd);
    logic [31:0] e_rd;
    logic        e_err;
    int          e_lat, e_nwr, lat, wr0;
    logic [31:0] e_word;
    model(we, sz, sg, addr, wd, e_rd, e_err, e_lat, e_nwr);
    exp_q.push_back(e_rd);
    e_word = ref_word(int'(addr[7:2]));
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    // Junk on the request fields must not disturb the latched transaction.
    req_valid  = 1'b0;
    req_we     = 1'($urandom_range(0, 1));
    req_size   = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && !e_err) check("mem_addr", mem_addr, addr >> 2);
    end while (!resp_valid && lat < 12);
    check("latency", 32'(lat), 32'(e_lat));
    obs_rd = resp_rdata;
    check("rdata", resp_rdata, exp_q.pop_front());
    check("err", 32'(resp_err), 32'(e_err));
    check("writes", 32'(wr_cnt - wr0), 32'(e_nwr));
    if (e_nwr == 1) check("mem_din", last_wr_data, e_word);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, e_rd);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_mem_enable", 32'(mem_enable), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] r;
    int wr0;
    int diff;
    for (int i = 0; i < 256; i++) ref_bytes[i] = 8'h00;

    // Reset held for two cycles.
    rst_n   = 1'b0;
    clr_mem = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_din", mem_din, 32'h0);
    rst_n   = 1'b1;
    clr_mem = 1'b0;

    // Word store / word load at 0x28.
    do_txn(1'b1, 2'b10, 1'b0, 32'h28, 32'hFFFF_FFFF, 0, r);
    do_txn(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 0, r);
    check("t2_word_load", r, 32'hFFFF_FFFF);

    // Byte store into a preloaded word, then signed/unsigned byte loads.
    do_txn(1'b1, 2'b10, 1'b0, 32'h04, 32'h1122_3344, 0, r);
    do_txn(1'b1, 2'b00, 1'b0, 32'h06, 32'h0000_00AB, 0, r);
    check("t3_mem_word", phys[1], 32'h11AB_3344);
    do_txn(1'b0, 2'b00, 1'b1, 32'h06, 32'h0, 0, r);
    check("t3_lb_signed", r, 32'hFFFF_FFAB);
    do_txn(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, 0, r);
    check("t3_lb_unsigned", r, 32'h0000_00AB);

    // Half loads from the upper half.
    do_txn(1'b1, 2'b10, 1'b0, 32'h04, 32'h8122_3344, 0, r);
    do_txn(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, 0, r);
    check("t4_lh_signed", r, 32'hFFFF_8122);
    do_txn(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 0, r);
    check("t4_lh_unsigned", r, 32'h0000_8122);

    // Response back-pressure for five cycles.
    do_txn(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 5, r);

    // Reset during a sub-word store before it reaches the write cycle.
    do_txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D, 0, r);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h11; req_wdata = 32'h55;
    wr0 = wr_cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_mem_enable", 32'(mem_enable), 32'd0);
    check("abort_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
    do_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, r);
    check("abort_mem_kept", r, 32'hCAFE_F00D);

    // Misaligned word load at 0x05.
    do_txn(1'b0, 2'b10, 1'b0, 32'h05, 32'h0, 0, r);
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    check("t6_misaligned", r, 32'h0);
`else
    check("t6_misaligned", r, 32'h8122_3344);
`endif

    // Address near the top of the space (word index wrap region).
    do_txn(1'b1, 2'b10, 1'b0, 32'hFFFF_FFF8, 32'h0BAD_BEEF, 0, r);

    // Randomized phase.
    for (int n = 0; n < 200; n++) begin
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom,
             $urandom_range(0, 2), r);
    end

    // Memory image must match the reference byte memory.
    diff = 0;
    for (int w = 0; w < 64; w++) if (phys[w] !== ref_word(w)) diff++;
    check("mem_image", 32'(diff), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
